sifive_insight_hart_0_counter_ctrl: RTL and testbench

//  Controller for hart 0's Insight event counters. Owns NUM_CNT counter channels.
//  Per channel it drives the event_sel/inc pair from a 32-bit hart event vector and

---
 rtl/sifive_insight_counter_pkg.sv | 30 +++
 rtl/sifive_insight_counter_chan.sv | 61 ++++++
 rtl/sifive_insight_hart_0_counter_ctrl.sv | 124 ++++++++++++
 tb/tb_sifive_insight_hart_0_counter_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifive_insight_counter_pkg.sv
// Shared types for the hart 0 Insight counter controller: cfg field decode,
// CTRL register bit positions and the cfg handshake FSM states.
package sifive_insight_counter_pkg;

    typedef enum logic [1:0] {
        EVSEL = 2'd0,
        COUNT = 2'd1,
        CTRL  = 2'd2,
        RSVD  = 2'd3
    } field_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_OVF_IE = 1;
    localparam int CTRL_OVF    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } fsm_e;

    function automatic logic [31:0] ctrl_word(input logic en, input logic ovf_ie, input logic ovf);
        logic [31:0] w;
        w              = '0;
        w[CTRL_EN]     = en;
        w[CTRL_OVF_IE] = ovf_ie;
        w[CTRL_OVF]    = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sifive_insight_counter_chan.sv
// One Insight counter channel: event selection, registered hit strobe, count,
// and the overflow flag with wrap-beats-clear and write-beats-increment priority.
module sifive_insight_counter_chan
    import sifive_insight_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      events,
    input  logic             freeze,
    input  logic             wr_evsel,
    input  logic             wr_count,
    input  logic             wr_ctrl,
    input  logic [31:0]      wdata,
    output logic [31:0]      event_sel,
    output logic [CNT_W-1:0] count,
    output logic             en,
    output logic             ovf_ie,
    output logic             ovf,
    output logic             inc
);

    logic hit;
    logic wrap;

    assign hit  = en & ~freeze & (|(events & event_sel));
    // A count write in the same cycle swallows the increment, so it cannot wrap.
    assign wrap = inc & ~wr_count & (&count);

    always_ff @(posedge clock) begin
        if (reset) begin
            event_sel <= '0;
            count     <= '0;
            en        <= 1'b0;
            ovf_ie    <= 1'b0;
            ovf       <= 1'b0;
            inc       <= 1'b0;
        end else begin
            inc <= hit;
            if (wr_evsel) begin
                event_sel <= wdata;
            end
            if (wr_count) begin
                count <= wdata[CNT_W-1:0];
            end else if (inc) begin
                count <= count + CNT_W'(1);
            end
            if (wr_ctrl) begin
                en     <= wdata[CTRL_EN];
                ovf_ie <= wdata[CTRL_OVF_IE];
            end
            if (wrap) begin
                ovf <= 1'b1;
            end else if (wr_ctrl && wdata[CTRL_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sifive_insight_hart_0_counter_ctrl.sv
// Hart 0 Insight counter controller: cfg request/response FSM, address decode,
// read mux and interrupt reduction over NUM_CNT counter channels.
module sifive_insight_hart_0_counter_ctrl
    import sifive_insight_counter_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           events,
    input  logic                  freeze,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_write,
    input  logic [4:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_CNT*32-1:0] cnt_event_sel,
    output logic [NUM_CNT-1:0]    cnt_inc,
    output logic                  irq,
    output fsm_e                  dbg_state
);

    // Handshake: a request transfers on a cycle with cfg_valid & cfg_ready; its
    // response is presented with rsp_valid, held stable, and retires on rsp_valid & rsp_ready.
    fsm_e                state;
    fsm_e                state_nxt;
    logic                accept;
    logic [2:0]          idx;
    field_e              field;
    logic                bad;
    logic [31:0]         rd_val;
    logic [NUM_CNT-1:0]  wr_ch;
    logic [CNT_W-1:0]    ch_count [NUM_CNT];
    logic [NUM_CNT-1:0]  ch_en;
    logic [NUM_CNT-1:0]  ch_ie;
    logic [NUM_CNT-1:0]  ch_ovf;

    assign idx       = cfg_addr[4:2];
    assign field     = field_e'(cfg_addr[1:0]);
    assign bad       = (field == RSVD) || (int'(idx) >= NUM_CNT);
    assign accept    = cfg_valid & cfg_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        wr_ch  = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (idx == 3'(i)) begin
                wr_ch[i] = accept & cfg_write & ~bad;
                case (field)
                    EVSEL:   rd_val = cnt_event_sel[i*32 +: 32];
                    COUNT:   rd_val = 32'(ch_count[i]);
                    CTRL:    rd_val = ctrl_word(ch_en[i], ch_ie[i], ch_ovf[i]);
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // Response payload is captured at accept and held for the whole RESP phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (accept) begin
                rsp_rdata <= (cfg_write || bad) ? 32'h0 : rd_val;
                rsp_err   <= bad;
            end
            irq <= |(ch_ovf & ch_ie);
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
        sifive_insight_counter_chan #(.CNT_W(CNT_W)) u_chan (
            .clock     (clock),
            .reset     (reset),
            .events    (events),
            .freeze    (freeze),
            .wr_evsel  (wr_ch[g] && (field == EVSEL)),
            .wr_count  (wr_ch[g] && (field == COUNT)),
            .wr_ctrl   (wr_ch[g] && (field == CTRL)),
            .wdata     (cfg_wdata),
            .event_sel (cnt_event_sel[g*32 +: 32]),
            .count     (ch_count[g]),
            .en        (ch_en[g]),
            .ovf_ie    (ch_ie[g]),
            .ovf       (ch_ovf[g]),
            .inc       (cnt_inc[g])
        );
    end

endmodule

// File: tb/tb_sifive_insight_hart_0_counter_ctrl.sv
// Bench for the hart 0 Insight counter controller: directed scenarios plus a
// randomized phase, all checked against a cycle-level reference model.
module tb_sifive_insight_hart_0_counter_ctrl;
    import sifive_insight_counter_pkg::*;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 32;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [31:0]           events = '0;
    logic                  freeze = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic                  cfg_write = 1'b0;
    logic [4:0]            cfg_addr = '0;
    logic [31:0]           cfg_wdata = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [NUM_CNT*32-1:0] cnt_event_sel;
    logic [NUM_CNT-1:0]    cnt_inc;
    logic                  irq;
    fsm_e                  dbg_state;

    always #5 clock = ~clock;

    sifive_insight_hart_0_counter_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .events        (events),
        .freeze        (freeze),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_write     (cfg_write),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .cnt_event_sel (cnt_event_sel),
        .cnt_inc       (cnt_inc),
        .irq           (irq),
        .dbg_state     (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state per channel plus the pending response queue.
    logic [31:0]      m_sel [NUM_CNT];
    logic [CNT_W-1:0] m_cnt [NUM_CNT];
    bit               m_en  [NUM_CNT];
    bit               m_ie  [NUM_CNT];
    bit               m_ovf [NUM_CNT];
    bit               m_inc [NUM_CNT];
    bit               m_irq;
    bit               m_busy;
    logic [32:0]      exp_q [$];

    always @(posedge clock) begin : model
        int   ch, fld;
        bit   acc, bad, irq_n, wr, wrap;
        bit   hit_n [NUM_CNT];
        logic [31:0] rd;
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                m_sel[i] = '0; m_cnt[i] = '0; m_en[i] = 0; m_ie[i] = 0; m_ovf[i] = 0; m_inc[i] = 0;
            end
            m_irq  = 0;
            m_busy = 0;
            exp_q.delete();
        end else begin
            ch    = int'(cfg_addr[4:2]);
            fld   = int'(cfg_addr[1:0]);
            bad   = (fld == 3) || (ch >= NUM_CNT);
            acc   = cfg_valid && !m_busy;
            irq_n = 0;
            for (int i = 0; i < NUM_CNT; i++) begin
                irq_n    = irq_n | (m_ovf[i] & m_ie[i]);
                hit_n[i] = m_en[i] && !freeze && ((events & m_sel[i]) != 0);
            end
            if (m_busy && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                rd = '0;
                if (!bad && !cfg_write) begin
                    case (fld)
                        0: rd = m_sel[ch];
                        1: rd = 32'(m_cnt[ch]);
                        default: rd = {29'b0, m_ovf[ch], m_ie[ch], m_en[ch]};
                    endcase
                end
                exp_q.push_back({bad, rd});
            end
            for (int i = 0; i < NUM_CNT; i++) begin
                wr   = acc && cfg_write && !bad && (ch == i);
                wrap = !(wr && fld == 1) && m_inc[i] && (m_cnt[i] == {CNT_W{1'b1}});
                if (wr && fld == 1) m_cnt[i] = cfg_wdata[CNT_W-1:0];
                else if (m_inc[i])  m_cnt[i] = m_cnt[i] + 1;
                if (wr && fld == 0) m_sel[i] = cfg_wdata;
                if (wr && fld == 2) begin
                    m_en[i] = cfg_wdata[0];
                    m_ie[i] = cfg_wdata[1];
                    if (cfg_wdata[2]) m_ovf[i] = 0;
                end
                if (wrap) m_ovf[i] = 1;
                m_inc[i] = hit_n[i];
            end
            m_irq = irq_n;
            if (acc) m_busy = 1;
            else if (m_busy && rsp_ready) m_busy = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_busy));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(m_busy));
            check_eq("dbg_state", 32'(dbg_state), 32'(m_busy));
            check_eq("irq", 32'(irq), 32'(m_irq));
            for (int i = 0; i < NUM_CNT; i++) begin
                check_eq($sformatf("cnt_inc%0d", i), 32'(cnt_inc[i]), 32'(m_inc[i]));
                check_eq($sformatf("event_sel%0d", i), cnt_event_sel[i*32 +: 32], m_sel[i]);
            end
            if (rsp_valid) begin
                check_eq("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
                    check_eq("rsp_err", 32'(rsp_err), 32'(exp_q[0][32]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] reg_addr(input int ch, input int fld);
        logic [2:0] c;
        logic [1:0] f;
        c = 3'(ch);
        f = 2'(fld);
        return {c, f};
    endfunction

    task automatic cfg_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        int guard;
        cfg_valid = 1'b1; cfg_write = wr; cfg_addr = addr; cfg_wdata = wd;
        guard = 0;
        while (!cfg_ready && guard < 50) begin tick(); guard++; end
        if (!cfg_ready) check_eq("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 50) begin tick(); guard++; end
        if (!rsp_valid) check_eq("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        rd  = rsp_rdata;
        err = rsp_err;
        guard = 0;
        tick();
        while (rsp_valid && guard < 50) begin tick(); guard++; end
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic e;
        cfg_xfer(1'b1, addr, wd, d, e);
    endtask

    task automatic rd_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic e;
        cfg_xfer(1'b0, addr, 32'h0, d, e);
        check_eq(tag, d, exp_d);
        check_eq({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic err_xfer(input string tag, input logic wr, input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic e;
        cfg_xfer(wr, addr, wd, d, e);
        check_eq({tag, "_rdata"}, d, 32'h0);
        check_eq({tag, "_err"}, 32'(e), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_cnt_inc", 32'(cnt_inc), 32'd0);

        // All fields of all channels read zero after reset; the reserved field errors.
        for (int c = 0; c < NUM_CNT; c++)
            for (int f = 0; f < 4; f++)
                rd_expect($sformatf("rst_ch%0d_f%0d", c, f), reg_addr(c, f), 32'h0, f == 3);

        // Several selected events in one cycle count once.
        wr_reg(reg_addr(0, 0), 32'h0000_0005);
        wr_reg(reg_addr(0, 2), 32'h1);
        events = 32'h1;
        repeat (3) tick();
        events = 32'h5;
        tick();
        events = 32'h0;
        check_eq("t2_inc_after_evt", 32'(cnt_inc[0]), 32'd1);
        tick();
        check_eq("t2_inc_idle", 32'(cnt_inc[0]), 32'd0);
        rd_expect("t2_count", reg_addr(0, 1), 32'd4, 1'b0);

        // Wrap from all-ones sets ovf and raises irq; W1C drops it.
        wr_reg(reg_addr(1, 0), 32'h2);
        wr_reg(reg_addr(1, 1), 32'hFFFF_FFFE);
        wr_reg(reg_addr(1, 2), 32'h3);
        events = 32'h2; tick(); events = 32'h0; tick(); tick();
        rd_expect("t3_count_ff", reg_addr(1, 1), 32'hFFFF_FFFF, 1'b0);
        events = 32'h2; tick(); events = 32'h0; tick(); tick();
        rd_expect("t3_count_wrap", reg_addr(1, 1), 32'h0, 1'b0);
        rd_expect("t3_ctrl_ovf", reg_addr(1, 2), 32'h7, 1'b0);
        check_eq("t3_irq_set", 32'(irq), 32'd1);
        wr_reg(reg_addr(1, 2), 32'h7);
        check_eq("t3_irq_clr", 32'(irq), 32'd0);
        rd_expect("t3_ctrl_clr", reg_addr(1, 2), 32'h3, 1'b0);

        // Freeze holds every channel; counting resumes one cycle after release.
        freeze = 1'b1; events = 32'h1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t4_frozen_inc", 32'(cnt_inc[0]), 32'd0);
        end
        rd_expect("t4_count_frozen", reg_addr(0, 1), 32'd4, 1'b0);
        freeze = 1'b0;
        check_eq("t4_release_inc0", 32'(cnt_inc[0]), 32'd0);
        tick();
        check_eq("t4_release_inc1", 32'(cnt_inc[0]), 32'd1);
        events = 32'h0;
        tick(); tick();
        rd_expect("t4_count_resumed", reg_addr(0, 1), 32'd5, 1'b0);

        // Count write beats a concurrent increment; wrap beats a concurrent W1C.
        events = 32'h1; tick(); events = 32'h0;
        check_eq("t5_inc_on_write", 32'(cnt_inc[0]), 32'd1);
        wr_reg(reg_addr(0, 1), 32'h10);
        rd_expect("t5_write_wins", reg_addr(0, 1), 32'h10, 1'b0);
        wr_reg(reg_addr(1, 1), 32'hFFFF_FFFF);
        events = 32'h2; tick(); events = 32'h0;
        check_eq("t5_inc_on_w1c", 32'(cnt_inc[1]), 32'd1);
        wr_reg(reg_addr(1, 2), 32'h7);
        rd_expect("t5_wrap_wins", reg_addr(1, 2), 32'h7, 1'b0);
        rd_expect("t5_wrap_count", reg_addr(1, 1), 32'h0, 1'b0);
        wr_reg(reg_addr(1, 2), 32'h4);
        rd_expect("t5_ch1_off", reg_addr(1, 2), 32'h0, 1'b0);

        // Error accesses return zero data and leave state untouched.
        err_xfer("t6_rsvd_rd", 1'b0, 5'h03, 32'h0);
        err_xfer("t6_rsvd_wr", 1'b1, 5'h03, 32'hFFFF_FFFF);
        err_xfer("t6_idx_wr", 1'b1, reg_addr(NUM_CNT, 1), 32'h1234);
        err_xfer("t6_idx_rd", 1'b0, reg_addr(NUM_CNT, 0), 32'h0);
        rd_expect("t6_evsel_kept", reg_addr(0, 0), 32'h5, 1'b0);
        rd_expect("t6_count_kept", reg_addr(0, 1), 32'h10, 1'b0);
        rd_expect("t6_ctrl_kept", reg_addr(0, 2), 32'h1, 1'b0);

        // Back-pressured response stays valid and stable.
        rsp_ready = 1'b0;
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = reg_addr(0, 0);
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("t6_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("t6_hold_ready", 32'(cfg_ready), 32'd0);
            check_eq("t6_hold_rdata", rsp_rdata, 32'h5);
            check_eq("t6_hold_err", 32'(rsp_err), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("t6_released_valid", 32'(rsp_valid), 32'd0);
        check_eq("t6_released_ready", 32'(cfg_ready), 32'd1);

        // Randomized traffic checked by the reference model.
        for (int k = 0; k < 800; k++) begin
            events    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_000F);
            freeze    = ($urandom_range(0, 9) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_valid = $urandom_range(0, 1);
            cfg_write = $urandom_range(0, 1);
            cfg_addr  = 5'($urandom_range(0, 31));
            cfg_wdata = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            tick();
        end
        cfg_valid = 1'b0; rsp_ready = 1'b1; events = '0; freeze = 1'b0;
        repeat (4) tick();
        for (int c = 0; c < NUM_CNT; c++)
            for (int f = 0; f < 3; f++) begin
                logic [31:0] d;
                logic e;
                cfg_xfer(1'b0, reg_addr(c, f), 32'h0, d, e);
            end

        // Reset during a held response drops it.
        rsp_ready = 1'b0;
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = reg_addr(0, 1);
        tick();
        cfg_valid = 1'b0;
        check_eq("t7_pending", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        check_eq("t7_rsp_dropped", 32'(rsp_valid), 32'd0);
        check_eq("t7_ready", 32'(cfg_ready), 32'd1);
        check_eq("t7_irq", 32'(irq), 32'd0);
        rd_expect("t7_count_cleared", reg_addr(0, 1), 32'h0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
